gf180mcu_fd_sc_mcu7t5v0__xnor_tree_pipe: RTL and testbench

//   Parametrised, pipelined N-input XOR/XNOR parity reducer; successor to the fixed 3-input xnor cells.
//   Per-transaction mode selects odd (XOR) or even (XNOR) reduction.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__xnor_tree_pipe.sv | 106 ++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__xnor_tree_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor_tree_pipe.sv
// Two-stage pipelined N-input XOR/XNOR parity reducer with expected-parity check and valid/ready flow control.
// Optional saturating error counter enabled by macro XNOR_TREE_PIPE_ERR_CNT_EN.
module gf180mcu_fd_sc_mcu7t5v0__xnor_tree_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GROUP = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic             INV,
  input  logic             CHK,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             ZN,
  output logic             ERR,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  input  logic             CLR,
  output logic [CNT_W-1:0] ERR_CNT,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam int unsigned NCH   = (WIDTH + GROUP - 1) / GROUP;
  localparam int unsigned PAD_W = NCH * GROUP;

  logic [PAD_W-1:0] a_pad_c;
  logic [NCH-1:0]   leaf_c;
  logic [NCH-1:0]   leaf_q;
  logic             inv1;
  logic             chk1;
  logic             v1;
  logic             en1;
  logic             en2;
  logic             zn_c;

  // Zero padding keeps parity unchanged when WIDTH is not a multiple of GROUP.
  assign a_pad_c = PAD_W'(A);

  for (genvar g = 0; g < NCH; g++) begin : g_leaf
    assign leaf_c[g] = ^a_pad_c[g*GROUP +: GROUP];
  end

  // Stage advance: a stage moves when its successor is empty or moving.
  assign en2      = ~OUT_VALID | OUT_READY;
  assign en1      = ~v1 | en2;
  assign IN_READY = en1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      v1     <= 1'b0;
      leaf_q <= '0;
      inv1   <= 1'b0;
      chk1   <= 1'b0;
    end else if (en1) begin
      v1 <= IN_VALID;
      if (IN_VALID) begin
        leaf_q <= leaf_c;
        inv1   <= INV;
        chk1   <= CHK;
      end
    end
  end

  assign zn_c = (^leaf_q) ^ inv1;

  // Result register holds while the downstream stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      ZN        <= 1'b0;
      ERR       <= 1'b0;
    end else if (en2) begin
      OUT_VALID <= v1;
      if (v1) begin
        ZN  <= zn_c;
        ERR <= zn_c ^ chk1;
      end
    end
  end

`ifdef XNOR_TREE_PIPE_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic unused_pins;
  assign unused_pins = ^{VDD, VSS};

  // Counts erroneous results at output handshake; clear has priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR_CNT <= '0;
    end else if (CLR) begin
      ERR_CNT <= '0;
    end else if (OUT_VALID && OUT_READY && ERR && (ERR_CNT != CNT_MAX)) begin
      ERR_CNT <= ERR_CNT + CNT_W'(1);
    end
  end
`else
  logic unused_pins;
  assign unused_pins = ^{VDD, VSS, CLR};

  assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__xnor_tree_pipe.sv
// Scoreboard bench for the pipelined parity reducer: directed vectors, backpressure, padding sweep,
// counter saturation/clear and reset during a stall.
module tb_gf180mcu_fd_sc_mcu7t5v0__xnor_tree_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned GROUP = 3;
  localparam int unsigned CNT_W = 2;
`ifdef XNOR_TREE_PIPE_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             CLK;
  logic             RST;
  logic [WIDTH-1:0] A;
  logic             INV;
  logic             CHK;
  logic             IN_VALID;
  logic             IN_READY;
  logic             ZN;
  logic             ERR;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             CLR;
  logic [CNT_W-1:0] ERR_CNT;
  wire              vdd = 1'b1;
  wire              vss = 1'b0;

  typedef struct packed {
    logic zn;
    logic err;
  } exp_t;

  exp_t             q[$];
  int               checks = 0;
  int               errors = 0;
  int               stall_left = 0;
  bit               saw_stall = 1'b0;
  logic [CNT_W-1:0] cnt_m = '0;

  gf180mcu_fd_sc_mcu7t5v0__xnor_tree_pipe #(
    .WIDTH(WIDTH),
    .GROUP(GROUP),
    .CNT_W(CNT_W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .A        (A),
    .INV      (INV),
    .CHK      (CHK),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .ZN       (ZN),
    .ERR      (ERR),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .CLR      (CLR),
    .ERR_CNT  (ERR_CNT),
    .VDD      (vdd),
    .VSS      (vss)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_ready();
    OUT_READY = (stall_left == 0);
    if (stall_left > 0) stall_left--;
  endtask

  task automatic idle(input int n);
    IN_VALID = 1'b0;
    repeat (n) begin
      drive_ready();
      @(negedge CLK);
    end
  endtask

  // Presents one beat at a negedge and waits for acceptance; pushes the hand-computed result.
  task automatic send(input logic [7:0] a, input logic inv, input logic chk, input logic exp_zn);
    int n = 0;
    A        = a;
    INV      = inv;
    CHK      = chk;
    IN_VALID = 1'b1;
    forever begin
      drive_ready();
      #1;
      if (IN_READY) begin
        q.push_back('{zn: exp_zn, err: exp_zn ^ chk});
        @(negedge CLK);
        break;
      end
      saw_stall = 1'b1;
      @(negedge CLK);
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: IN_READY stuck low for beat %0h", a);
        IN_VALID = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    RST        = 1'b1;
    IN_VALID   = 1'b0;
    CLR        = 1'b0;
    stall_left = 0;
    OUT_READY  = 1'b1;
    q.delete();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Monitor: pops and compares on every output handshake; checks hold stability during stalls.
  initial begin
    bit   held = 1'b0;
    logic hz = 1'b0;
    logic he = 1'b0;
    exp_t e;
    bit   hs;
    forever begin
      @(negedge CLK);
      #2;
      if (RST) begin
        held  = 1'b0;
        cnt_m = '0;
      end else begin
        if (held) begin
          check("hold_valid", OUT_VALID, 1);
          check("hold_zn", ZN, hz);
          check("hold_err", ERR, he);
        end
        hs = OUT_VALID && OUT_READY;
        e  = '0;
        if (hs) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got zn=%0b with no beat outstanding, expected none", ZN);
          end else begin
            e = q.pop_front();
            check("zn", ZN, e.zn);
            check("err", ERR, e.err);
          end
          check("err_cnt", ERR_CNT, cnt_m);
        end
        held = OUT_VALID && !OUT_READY;
        hz   = ZN;
        he   = ERR;
        if (CNT_EN) begin
          if (CLR) cnt_m = '0;
          else if (hs && e.err && (cnt_m != '1)) cnt_m = cnt_m + CNT_W'(1);
        end
      end
    end
  end

  initial begin
    logic [7:0] a;
    A         = '0;
    INV       = 1'b0;
    CHK       = 1'b0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    CLR       = 1'b0;
    RST       = 1'b1;
    do_reset();

    check("rst_out_valid", OUT_VALID, 0);
    check("rst_zn", ZN, 0);
    check("rst_err", ERR, 0);
    check("rst_err_cnt", ERR_CNT, 0);

    // Parity: B4 has four ones, XOR mode, latency of two edges.
    send(8'hB4, 1'b0, 1'b0, 1'b0);
    check("lat_not_yet", OUT_VALID, 0);
    idle(1);
    check("lat_valid", OUT_VALID, 1);
    check("t1_zn", ZN, 0);
    check("t1_err", ERR, 0);
    idle(2);

    // Mode: XNOR of the same data.
    send(8'hB4, 1'b1, 1'b0, 1'b1);
    idle(1);
    check("t2_zn", ZN, 1);
    check("t2_err", ERR, 1);
    idle(3);
    check("t2_err_cnt", ERR_CNT, CNT_EN ? 1 : 0);

    // Backpressure: stall the output for three cycles after two beats.
    saw_stall = 1'b0;
    send(8'h01, 1'b0, 1'b0, 1'b1);
    send(8'h03, 1'b0, 1'b0, 1'b0);
    stall_left = 3;
    send(8'h07, 1'b0, 1'b0, 1'b1);
    send(8'h0F, 1'b0, 1'b0, 1'b0);
    check("bp_in_ready_fell", saw_stall, 1);
    idle(4);
    check("bp_drained", q.size(), 0);

    // Padding: only the top bit set lands in the padded last leaf.
    send(8'h80, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Sweep all data values in both modes with occasional stalls.
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      if (i % 40 == 7) stall_left = 2;
      send(a, a[0], a[1], (^a) ^ a[0]);
    end
    idle(6);
    check("sweep_drained", q.size(), 0);

    // Reset while both stages are full and the output is stalled.
    stall_left = 20;
    send(8'h01, 1'b1, 1'b1, 1'b0);
    send(8'h03, 1'b1, 1'b0, 1'b1);
    #1;
    check("pre_rst_in_ready", IN_READY, 0);
    check("pre_rst_out_valid", OUT_VALID, 1);
    do_reset();
    #1;
    check("midrst_out_valid", OUT_VALID, 0);
    check("midrst_in_ready", IN_READY, 1);
    check("midrst_err_cnt", ERR_CNT, 0);
    @(negedge CLK);

    // Counter: five error beats saturate a 2-bit counter, then clear beats a simultaneous error.
    repeat (5) send(8'hB4, 1'b1, 1'b0, 1'b1);
    idle(4);
    check("cnt_sat", ERR_CNT, CNT_EN ? 3 : 0);
    send(8'hB4, 1'b1, 1'b0, 1'b1);
    idle(1);
    check("clr_beat_valid", OUT_VALID, 1);
    CLR = 1'b1;
    idle(1);
    CLR = 1'b0;
    check("cnt_clr", ERR_CNT, 0);
    idle(4);
    check("final_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
